// File: rtl/sync_debounce_if.sv
// Connects the raw input and sample tick to the debouncer and returns its
// conditioned level and edge pulses.
interface sync_debounce_if;
    logic din;
    logic en;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    // Producer of the raw input and sample tick; consumer of the clean outputs
    modport master (
        output din,
        output en,
        input  dout,
        input  rise,
        input  fall,
        input  busy
    );

    // The debouncer itself
    modport slave (
        input  din,
        input  en,
        output dout,
        output rise,
        output fall,
        output busy
    );
endinterface

// File: rtl/sync_debounce.sv
// Input conditioner: a metastability synchronizer followed by a debounce FSM.
// A change on the synchronized input must stay stable for DB_CYCLES
// en-qualified samples before dout follows it, with a one-cycle rise/fall pulse.
module sync_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 4,
    parameter int unsigned CNT_W       = 16,
    parameter bit          RESET_VAL   = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    sync_debounce_if.slave bus
);

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_RISE_CHK = 2'd1,
        ST_HIGH     = 2'd2,
        ST_FALL_CHK = 2'd3
    } state_e;

    localparam state_e           RESET_ST = RESET_VAL ? ST_HIGH : ST_LOW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s_c;

    state_e                 state_q;
    state_e                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   dout_q;
    logic                   dout_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   busy_q;
    logic                   busy_d;

    // Synchronizer shift: new sample enters at stage 0, last stage feeds the FSM
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.din};
    end

    assign s_c = sync_q[SYNC_STAGES-1];

    // State register plus all registered outputs and the qualifying counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            state_q <= RESET_ST;
            cnt_q   <= '0;
            dout_q  <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state: a reversion of s always wins over count completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOW: begin
                if (s_c) state_d = ST_RISE_CHK;
            end
            ST_RISE_CHK: begin
                if (!s_c)                             state_d = ST_LOW;
                else if (bus.en && cnt_q == CNT_LAST) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (!s_c) state_d = ST_FALL_CHK;
            end
            ST_FALL_CHK: begin
                if (s_c)                              state_d = ST_HIGH;
                else if (bus.en && cnt_q == CNT_LAST) state_d = ST_LOW;
            end
            default: state_d = ST_LOW;
        endcase
    end

    // Output/counter next values; pulses default low so they last one cycle
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        busy_d = busy_q;
        case (state_q)
            ST_LOW: begin
                if (s_c) begin
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end
            end
            ST_RISE_CHK: begin
                if (!s_c) begin
                    cnt_d  = '0;
                    busy_d = 1'b0;
                end else if (bus.en) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        dout_d = 1'b1;
                        rise_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_HIGH: begin
                if (!s_c) begin
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end
            end
            ST_FALL_CHK: begin
                if (s_c) begin
                    cnt_d  = '0;
                    busy_d = 1'b0;
                end else if (bus.en) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        dout_d = 1'b0;
                        fall_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                cnt_d  = '0;
                dout_d = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.dout = dout_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
    assign bus.busy = busy_q;

endmodule
